// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM driven from one shared prescaled counter, with
// edge/center alignment and double-buffered duties that are applied only at period boundaries.
module pwm_bank #(
    parameter int CHANNELS   = 8,
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 8,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  center,
    input  logic                  wr_en,
    input  logic [CW-1:0]         wr_chan,
    input  logic [WIDTH-1:0]      wr_duty,
    input  logic                  commit,
    output logic                  commit_pending,
    output logic                  period_start,
    output logic [CHANNELS-1:0]   pwm_out
);
    localparam logic [WIDTH-1:0]      CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]      CNT_ONE = WIDTH'(1);
    localparam logic [PRESCALE_W-1:0] PRE_ONE = PRESCALE_W'(1);
    localparam logic [CW:0]           CH_LIM  = (CW+1)'(CHANNELS);

    logic [PRESCALE_W-1:0] pre_cnt_r;
    logic [PRESCALE_W-1:0] prescale_act_r;
    logic                  center_act_r;
    logic [WIDTH-1:0]      cnt_r;
    logic                  dir_down_r;
    logic                  first_r;
    logic [WIDTH-1:0]      shadow_r   [CHANNELS];
    logic [WIDTH-1:0]      duty_act_r [CHANNELS];

    logic                  tick_s;
    logic                  terminal_s;
    logic                  boundary_s;
    logic                  apply_s;
    logic                  wr_ok_s;
    logic [PRESCALE_W-1:0] pre_nx_s;
    logic [WIDTH-1:0]      cnt_nx_s;
    logic                  dir_nx_s;

    // first_r forces a boundary on the first clock after reset so the counter starts a clean period.
    assign tick_s     = (pre_cnt_r == prescale_act_r);
    assign terminal_s = tick_s && (center_act_r ? (dir_down_r && (cnt_r == CNT_ONE))
                                                : (cnt_r == CNT_MAX));
    assign boundary_s = terminal_s || first_r;
    assign apply_s    = boundary_s && (commit_pending || commit);
    assign wr_ok_s    = wr_en && ({1'b0, wr_chan} < CH_LIM);

    // Next prescaler/counter/direction values: boundary restarts, tick advances, otherwise prescale.
    always_comb begin
        pre_nx_s = pre_cnt_r;
        cnt_nx_s = cnt_r;
        dir_nx_s = dir_down_r;
        if (boundary_s) begin
            pre_nx_s = '0;
            cnt_nx_s = '0;
            dir_nx_s = 1'b0;
        end else if (tick_s) begin
            pre_nx_s = '0;
            if (!center_act_r) begin
                cnt_nx_s = cnt_r + CNT_ONE;
            end else if (dir_down_r) begin
                cnt_nx_s = cnt_r - CNT_ONE;
            end else if (cnt_r == CNT_MAX) begin
                cnt_nx_s = cnt_r - CNT_ONE;
                dir_nx_s = 1'b1;
            end else begin
                cnt_nx_s = cnt_r + CNT_ONE;
            end
        end else begin
            pre_nx_s = pre_cnt_r + PRE_ONE;
        end
    end

    // State, duty buffers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_r      <= '0;
            prescale_act_r <= '0;
            center_act_r   <= 1'b0;
            cnt_r          <= '0;
            dir_down_r     <= 1'b0;
            first_r        <= 1'b1;
            commit_pending <= 1'b0;
            period_start   <= 1'b0;
            pwm_out        <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_r[i]   <= '0;
                duty_act_r[i] <= '0;
            end
        end else begin
            pre_cnt_r    <= pre_nx_s;
            cnt_r        <= cnt_nx_s;
            dir_down_r   <= dir_nx_s;
            period_start <= boundary_s;
            for (int i = 0; i < CHANNELS; i++) begin
                pwm_out[i] <= (cnt_r < duty_act_r[i]);
            end
            if (boundary_s) begin
                prescale_act_r <= prescale;
                center_act_r   <= center;
                first_r        <= 1'b0;
            end
            // Active copy takes the pre-write shadow; a same-cycle write lands in shadow only.
            if (apply_s) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    duty_act_r[i] <= shadow_r[i];
                end
                commit_pending <= 1'b0;
            end else if (commit) begin
                commit_pending <= 1'b1;
            end
            if (wr_ok_s) begin
                shadow_r[wr_chan] <= wr_duty;
            end
        end
    end
endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank (4 channels, 4-bit duty): directed test-plan steps
// plus random traffic, all checked every clock against a period-arithmetic reference model.
module tb_pwm_bank;
    localparam int CH   = 4;
    localparam int W    = 4;
    localparam int PW   = 8;
    localparam int MAXV = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] prescale = '0;
    logic          center = 1'b0;
    logic          wr_en = 1'b0;
    logic [1:0]    wr_chan = '0;
    logic [W-1:0]  wr_duty = '0;
    logic          commit = 1'b0;
    logic          commit_pending;
    logic          period_start;
    logic [CH-1:0] pwm_out;

    int total = 0;
    int bad   = 0;

    // reference model state (period position arithmetic)
    bit            m_first;
    int            m_k, m_p;
    bit            m_center, m_pend;
    int            m_shadow [CH];
    int            m_act    [CH];
    logic [CH-1:0] e_pwm;
    logic          e_ps;

    int            meas_len;
    int            meas_hi [CH];
    logic [127:0]  meas_pat;
    logic [7:0]    wide_chan;

    pwm_bank #(.CHANNELS(CH), .WIDTH(W), .PRESCALE_W(PW)) dut (
        .clk(clk), .rst(rst), .prescale(prescale), .center(center),
        .wr_en(wr_en), .wr_chan(wr_chan), .wr_duty(wr_duty), .commit(commit),
        .commit_pending(commit_pending), .period_start(period_start), .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int cnt_at(int k, int p, bit c);
        int t;
        t = k / (p + 1);
        if (!c) return t;
        return (t <= MAXV) ? t : 2 * MAXV - t;
    endfunction

    function automatic int period_len(int p, bit c);
        return c ? (p + 1) * 2 * MAXV : (p + 1) * (MAXV + 1);
    endfunction

    task automatic clk_step();
        int  cnt_now;
        bit  bnd;
        @(posedge clk);
        if (rst) begin
            m_first = 1'b1; m_k = 0; m_p = 0; m_center = 1'b0; m_pend = 1'b0;
            for (int i = 0; i < CH; i++) begin m_shadow[i] = 0; m_act[i] = 0; end
            e_pwm = '0; e_ps = 1'b0;
        end else begin
            cnt_now = cnt_at(m_k, m_p, m_center);
            for (int i = 0; i < CH; i++) e_pwm[i] = (cnt_now < m_act[i]);
            bnd  = m_first || (m_k == period_len(m_p, m_center) - 1);
            e_ps = bnd;
            if (bnd) begin
                if (m_pend || commit) for (int i = 0; i < CH; i++) m_act[i] = m_shadow[i];
                m_pend = 1'b0; m_p = int'(prescale); m_center = center; m_k = 0; m_first = 1'b0;
            end else begin
                m_k++;
                if (commit) m_pend = 1'b1;
            end
            if (wr_en && int'(wr_chan) < CH) m_shadow[wr_chan] = int'(wr_duty);
        end
        @(negedge clk);
        chk("pwm_out", 32'(pwm_out), 32'(e_pwm));
        chk("period_start", 32'(period_start), 32'(e_ps));
        chk("commit_pending", 32'(commit_pending), 32'(m_pend));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) clk_step();
    endtask

    task automatic wait_ps(input int budget);
        int n;
        n = 0;
        do begin clk_step(); n++; end while (period_start !== 1'b1 && n < budget);
        if (period_start !== 1'b1) chk("wait_ps_timeout", 32'(period_start), 32'd1);
    endtask

    // counts clocks and high samples from now up to and including the next period_start
    task automatic measure();
        meas_len = 0; meas_pat = '0;
        for (int i = 0; i < CH; i++) meas_hi[i] = 0;
        do begin
            clk_step();
            if (meas_len < 128) meas_pat[meas_len] = pwm_out[1];
            meas_len++;
            for (int i = 0; i < CH; i++) meas_hi[i] += int'(pwm_out[i]);
        end while (period_start !== 1'b1 && meas_len < 200);
        if (meas_len >= 200) chk("period_timeout", 32'(period_start), 32'd1);
    endtask

    task automatic write(input int ch, input int d);
        wr_en = 1'b1; wr_chan = 2'(ch); wr_duty = 4'(d);
        clk_step();
        wr_en = 1'b0;
    endtask

    initial begin
        steps(2);
        chk("reset_pwm", 32'(pwm_out), 32'd0);
        chk("reset_ps", 32'(period_start), 32'd0);
        rst = 1'b0;

        // basic edge mode
        write(0, 0);
        chk("forced_boundary_ps", 32'(period_start), 32'd1);
        write(1, 4); write(2, 15); write(3, 8);
        commit = 1'b1; clk_step(); commit = 1'b0;
        wait_ps(40);
        measure();
        chk("edge_len", meas_len, 32'd16);
        chk("edge_hi0", meas_hi[0], 32'd0);
        chk("edge_hi1", meas_hi[1], 32'd4);
        chk("edge_hi2", meas_hi[2], 32'd15);
        chk("edge_hi3", meas_hi[3], 32'd8);

        // center mode, latched at the end of the current edge period
        center = 1'b1;
        measure();
        chk("center_latch_len", meas_len, 32'd16);
        measure();
        chk("ctr_len", meas_len, 32'd30);
        chk("ctr_hi0", meas_hi[0], 32'd0);
        chk("ctr_hi1", meas_hi[1], 32'd7);
        chk("ctr_hi2", meas_hi[2], 32'd29);
        chk("ctr_hi3", meas_hi[3], 32'd15);
        chk("ctr_shape", meas_pat[31:0], 32'h3800_000F);
        center = 1'b0;
        measure();
        chk("ctr_len2", meas_len, 32'd30);

        // prescaler change mid-period
        steps(5);
        prescale = 8'd2;
        measure();
        chk("pre_old_len", meas_len + 5, 32'd16);
        prescale = 8'd0;
        measure();
        chk("pre_len", meas_len, 32'd48);
        chk("pre_hi1", meas_hi[1], 32'd12);
        chk("pre_hi2", meas_hi[2], 32'd45);
        chk("pre_hi3", meas_hi[3], 32'd24);

        // double buffering
        write(2, 10);
        measure();
        for (int p = 0; p < 3; p++) begin
            measure();
            chk("dbuf_hold_hi2", meas_hi[2], 32'd15);
        end
        steps(4);
        commit = 1'b1; clk_step(); commit = 1'b0;
        chk("dbuf_pending", 32'(commit_pending), 32'd1);
        wait_ps(40);
        chk("dbuf_pending_clr", 32'(commit_pending), 32'd0);
        measure();
        chk("dbuf_hi2", meas_hi[2], 32'd10);

        // write + commit on the terminal tick
        write(0, 9);
        steps(14);
        wr_en = 1'b1; wr_chan = 2'd0; wr_duty = 4'd3; commit = 1'b1;
        clk_step();
        wr_en = 1'b0; commit = 1'b0;
        chk("coll_ps", 32'(period_start), 32'd1);
        chk("coll_pend", 32'(commit_pending), 32'd0);
        measure();
        chk("coll_hi0", meas_hi[0], 32'd9);
        commit = 1'b1; clk_step(); commit = 1'b0;
        wait_ps(40);
        measure();
        chk("coll_second_hi0", meas_hi[0], 32'd3);

        // reset mid-period with a commit pending and an out-of-range channel
        commit = 1'b1; clk_step(); commit = 1'b0;
        steps(3);
        wide_chan = 8'd5;
        rst = 1'b1; wr_en = 1'b1; wr_chan = wide_chan[1:0]; wr_duty = 4'd7;
        clk_step();
        chk("rst_pwm", 32'(pwm_out), 32'd0);
        chk("rst_pend", 32'(commit_pending), 32'd0);
        rst = 1'b0; wr_en = 1'b0;
        clk_step();
        chk("rst_release_ps", 32'(period_start), 32'd1);
        commit = 1'b1; clk_step(); commit = 1'b0;
        wait_ps(40);
        measure();
        chk("rst_len", meas_len, 32'd16);
        for (int i = 0; i < CH; i++) chk("rst_hi", meas_hi[i], 32'd0);

        // random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            rst     = ($urandom_range(0, 199) == 0);
            wr_en   = 1'($urandom_range(0, 1));
            wr_chan = 2'($urandom_range(0, 3));
            wr_duty = 4'($urandom);
            commit  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 63) == 0) prescale = 8'($urandom_range(0, 2));
            if ($urandom_range(0, 63) == 0) center = 1'($urandom_range(0, 1));
            clk_step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pwm_bank.md
# pwm_bank

Parametrised multi-channel PWM generator: the next generation of the single-channel, fixed-duty LED PWM in the Mojo top level. It drives `CHANNELS` outputs from one shared period counter with a programmable prescaler. Each channel has its own runtime-writable duty with double buffering, so duty updates never glitch mid-period. It supports edge-aligned and center-aligned modes and sits between control logic (SPI/AVR register writes, counters) and the LED or pin outputs.

## Interface
- `CHANNELS`, 8: number of PWM outputs (1–32).
- `WIDTH`, 8: duty/counter width; MAX = 2^WIDTH−1.
- `PRESCALE_W`, 8: prescaler width.
- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  reset, synchronous, active-high; one clock; all state sampled on rising `clk`.
- `prescale`  in  PRESCALE_W  counter advances once per `prescale`+1 clocks; latched at period boundary.
- `center`  in  1  0 = edge-aligned, 1 = center-aligned; latched at period boundary.
- `wr_en`  in  1  write `wr_duty` into shadow duty of channel `wr_chan`.
- `wr_chan`  in  max(1,$clog2(CHANNELS))  target channel.
- `wr_duty`  in  WIDTH  duty value.
- `commit`  in  1  request shadow→active copy at next period boundary.
- `commit_pending`  out  1  commit requested, not yet applied.
- `period_start`  out  1  one-cycle pulse per period boundary.
- `pwm_out`  out  CHANNELS  PWM outputs, registered.

## Operation
- Prescaler `pre_cnt` counts 0..`prescale_act`; `tick` = (`pre_cnt` == `prescale_act`), then `pre_cnt` returns to 0.
- Edge mode: on each tick, `cnt` goes 0,1,…,MAX,0. Terminal = tick with `cnt`==MAX. Period = 2^WIDTH ticks.
- Center mode: on each tick, `cnt` goes 0,1,…,MAX,MAX−1,…,1,0 via a direction flag. Terminal = tick with `cnt`==1 and direction down. Period = 2·MAX ticks.
- Output per channel: `pwm_out[i]` <= (`cnt` < `duty_act[i]`).
  - Edge: high for `duty` ticks per period. Duty 0 gives constant low; duty MAX gives low for exactly one tick.
  - Center: high for 2·`duty`−1 ticks (duty ≥ 1), centred on `cnt`=0. Duty 0 gives constant low.
- Boundary event = terminal tick, or the first clock with `rst` low after reset (forced boundary). At a boundary:
  - `prescale_act`, `center_act` <= inputs.
  - If `commit_pending` or `commit`: every `duty_act[i]` <= `shadow[i]` (pre-write value); `commit_pending` <= 0.
  - `cnt` <= 0, direction <= up, `pre_cnt` <= 0.
- Shadow writes: `shadow[wr_chan]` <= `wr_duty` whenever `wr_en`. Writes with `wr_chan` ≥ CHANNELS are ignored. Writes never affect `duty_act` directly.
- `commit` outside a boundary sets `commit_pending`. Repeated commits while pending are idempotent.
- Write, `commit` and boundary in the same cycle: the old shadow values are copied to active; the new write lands in shadow only; pending is cleared.
- `prescale` and `center` changes mid-period are ignored until the next boundary.
- Reset (any cycle, including mid-period or mid-commit):
  - `cnt`, `pre_cnt`, `prescale_act`, `center_act`, all shadow and active duties, and `commit_pending` go to 0.
  - Direction goes to up; `pwm_out` = 0; `period_start` = 0.
  - A pending commit is discarded.

## Timing
- `pwm_out` lags `cnt` by one clock. Registered outputs only; no combinational input→output path.
- `period_start` goes high the clock after a boundary event, for exactly one cycle. This includes the forced boundary, so the first pulse comes 1 clock after `rst` falls.
- New duties first appear on `pwm_out` 1 clock after the boundary that applied them.
- `commit_pending` rises 1 clock after `commit` (non-boundary cycle) and falls 1 clock after the applying boundary.
- With `prescale`=P, one period lasts (P+1)·2^WIDTH clocks in edge mode and (P+1)·2·MAX clocks in center mode.
- Write-to-effect worst case: one full period plus 1 clock after `commit`.

## Test plan
- Basic edge mode (CHANNELS=4, WIDTH=4, `prescale`=0): write duties 0, 4, 15, 8, then `commit`.
  - Required: from the next period, counts of high clocks per 16-clock period are 0, 4, 15, 8.
  - `period_start` pulses every 16 clocks.
- Center mode (`center`=1, duty 4 on ch1, `prescale`=0): per 30-clock period, ch1 is high for 7 contiguous clocks spanning the wrap of `cnt` through 0; duty 0 stays low.
- Prescaler change: `prescale`=2 applied mid-period.
  - Current period keeps its old length.
  - The following period is 48 clocks (edge, WIDTH=4) with unchanged duty ratios.
- Double buffering: write duty 10 without `commit`, check `pwm_out` is unchanged across 3 periods; then `commit` mid-period.
  - `commit_pending`=1 until the boundary.
  - Duty 10 takes effect exactly at the next `period_start`.
- Boundary collision: `wr_en` (ch0, duty 3) with `commit` on the terminal tick, shadow ch0 previously 9.
  - Active ch0 becomes 9; shadow ch0 = 3; `commit_pending`=0.
  - A second `commit` later applies 3.
- Reset mid-operation: assert `rst` mid-period with a commit pending and `wr_chan`=5 on CHANNELS=4.
  - All outputs go to 0 the next clock.
  - The pending commit is dropped; the out-of-range write has no effect.
  - `period_start` pulses 1 clock after release.
